// File: rtl/window_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : window_pkg
//  Purpose  : Shared pixel and window dimensions for the 3x3 window generator.
//  Revision : 1.0
// ============================================================================
package window_pkg;
    localparam int PIX_W = 8;
    localparam int WIN_N = 3;
endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : line_buffer
//  Purpose  : One-row pixel store, one write and one asynchronous read port.
//  Revision : 1.0
// ============================================================================
module line_buffer #(
    parameter int DEPTH = 320,
    parameter int WIDTH = 8
) (
    input  logic                     iClk,
    input  logic                     iWrEn,
    input  logic [$clog2(DEPTH)-1:0] iAddr,
    input  logic [WIDTH-1:0]         iData,
    output logic [WIDTH-1:0]         oData
);
    // No reset: contents are never observed until fully rewritten.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge iClk) begin
        if (iWrEn) begin
            r_mem[iAddr] <= iData;
        end
    end

    assign oData = r_mem[iAddr];
endmodule
`default_nettype wire

// File: rtl/window_3x3_gen.sv
`default_nettype none
// ============================================================================
//  Module   : window_3x3_gen
//  Purpose  : Raster stream to 3x3 neighbourhood windows (interior centres).
//  Revision : 1.0
// ============================================================================
module window_3x3_gen
    import window_pkg::*;
#(
    parameter int pWidth  = 320,
    parameter int pHeight = 240
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iDataValid,
    input  logic             iSof,
    input  logic [PIX_W-1:0] iv8Pixel,
    output logic [PIX_W-1:0] ov8Pixel_a,
    output logic [PIX_W-1:0] ov8Pixel_b,
    output logic [PIX_W-1:0] ov8Pixel_c,
    output logic [PIX_W-1:0] ov8Pixel_d,
    output logic [PIX_W-1:0] ov8Pixel_fij,
    output logic [PIX_W-1:0] ov8Pixel_e,
    output logic [PIX_W-1:0] ov8Pixel_f,
    output logic [PIX_W-1:0] ov8Pixel_g,
    output logic [PIX_W-1:0] ov8Pixel_h,
    output logic             oDataValid,
    output logic             oFrameDone,
    output logic             oSofErr
);
    localparam int COL_W = $clog2(pWidth);
    localparam int ROW_W = $clog2(pHeight);
    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(pWidth - 1);
    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(pHeight - 1);
    localparam logic [COL_W-1:0] c_COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] c_ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0] c_COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] c_ROW_TWO  = ROW_W'(2);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic [PIX_W-1:0] w_lb1_q;
    logic [PIX_W-1:0] w_lb2_q;
    logic [PIX_W-1:0] r_win      [WIN_N][WIN_N];
    logic [PIX_W-1:0] w_win_next [WIN_N][WIN_N];
    logic [PIX_W-1:0] r_out      [WIN_N][WIN_N];
    logic             w_emit;
    logic             w_last;
    logic             w_sof_err;
    logic             w_wr_en;
    logic             r_valid;
    logic             r_fdone;
    logic             r_sof_err;

    // A start-of-frame pixel is position (0,0) whatever the counters say.
    assign w_col     = iSof ? '0 : r_col;
    assign w_row     = iSof ? '0 : r_row;
    assign w_emit    = iDataValid && (w_row >= c_ROW_TWO) && (w_col >= c_COL_TWO);
    assign w_last    = (w_col == c_COL_LAST) && (w_row == c_ROW_LAST);
    assign w_sof_err = iDataValid && iSof && ((r_col != '0) || (r_row != '0));
    assign w_wr_en   = iDataValid && !iRst;

    // lb1 holds row r-1; its old entry cascades into lb2 (row r-2).
    line_buffer #(.DEPTH(pWidth), .WIDTH(PIX_W)) u_lb1 (
        .iClk  (iClk),
        .iWrEn (w_wr_en),
        .iAddr (w_col),
        .iData (iv8Pixel),
        .oData (w_lb1_q)
    );

    line_buffer #(.DEPTH(pWidth), .WIDTH(PIX_W)) u_lb2 (
        .iClk  (iClk),
        .iWrEn (w_wr_en),
        .iAddr (w_col),
        .iData (w_lb1_q),
        .oData (w_lb2_q)
    );

    always_comb begin
        for (int i = 0; i < WIN_N; i++) begin
            for (int j = 0; j < WIN_N - 1; j++) begin
                w_win_next[i][j] = r_win[i][j+1];
            end
        end
        w_win_next[0][WIN_N-1] = w_lb2_q;
        w_win_next[1][WIN_N-1] = w_lb1_q;
        w_win_next[2][WIN_N-1] = iv8Pixel;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_col     <= '0;
            r_row     <= '0;
            r_win     <= '{default: '0};
            r_out     <= '{default: '0};
            r_valid   <= 1'b0;
            r_fdone   <= 1'b0;
            r_sof_err <= 1'b0;
        end else begin
            r_valid   <= w_emit;
            r_fdone   <= w_emit && w_last;
            r_sof_err <= w_sof_err;
            if (iDataValid) begin
                r_win <= w_win_next;
                if (w_emit) begin
                    r_out <= w_win_next;
                end
                if (w_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_row <= (w_row == c_ROW_LAST) ? '0 : w_row + c_ROW_ONE;
                end else begin
                    r_col <= w_col + c_COL_ONE;
                    r_row <= w_row;
                end
            end
        end
    end

    assign ov8Pixel_a   = r_out[0][0];
    assign ov8Pixel_b   = r_out[0][1];
    assign ov8Pixel_c   = r_out[0][2];
    assign ov8Pixel_d   = r_out[1][0];
    assign ov8Pixel_fij = r_out[1][1];
    assign ov8Pixel_e   = r_out[1][2];
    assign ov8Pixel_f   = r_out[2][0];
    assign ov8Pixel_g   = r_out[2][1];
    assign ov8Pixel_h   = r_out[2][2];
    assign oDataValid   = r_valid;
    assign oFrameDone   = r_fdone;
    assign oSofErr      = r_sof_err;
endmodule
`default_nettype wire

// File: tb/tb_window_3x3_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_window_3x3_gen
//  Purpose  : Directed self-checking bench for window_3x3_gen (5x4 image).
//  Revision : 1.0
// ============================================================================
module tb_window_3x3_gen;
    localparam int W = 5;
    localparam int H = 4;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iDataValid;
    logic       iSof;
    logic [7:0] iv8Pixel;
    logic [7:0] pa, pb, pc, pd, pfij, pe, pf, pg, ph;
    logic       oDataValid, oFrameDone, oSofErr;

    int errors = 0;
    int checks = 0;

    logic [71:0] win_q[$];
    logic        fd_q[$];
    int          sof_err_cnt;
    int          fd_stray;
    int          first_emit_pix;

    window_3x3_gen #(.pWidth(W), .pHeight(H)) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iDataValid   (iDataValid),
        .iSof         (iSof),
        .iv8Pixel     (iv8Pixel),
        .ov8Pixel_a   (pa),
        .ov8Pixel_b   (pb),
        .ov8Pixel_c   (pc),
        .ov8Pixel_d   (pd),
        .ov8Pixel_fij (pfij),
        .ov8Pixel_e   (pe),
        .ov8Pixel_f   (pf),
        .ov8Pixel_g   (pg),
        .ov8Pixel_h   (ph),
        .oDataValid   (oDataValid),
        .oFrameDone   (oFrameDone),
        .oSofErr      (oSofErr)
    );

    always #5 iClk = ~iClk;

    function automatic logic [71:0] cur_win();
        return {pa, pb, pc, pd, pfij, pe, pf, pg, ph};
    endfunction

    // Expected window centred on (r,c) of an image whose pixel is base+10*r+c.
    function automatic logic [71:0] win_at(input int base, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                w = {w[63:0], 8'(base + 10 * (r + dr) + (c + dc))};
            end
        end
        return w;
    endfunction

    task automatic drive(input logic rst, input logic v, input logic s, input logic [7:0] p);
        iRst = rst; iDataValid = v; iSof = s; iv8Pixel = p;
        @(posedge iClk);
        #1;
        if (oDataValid) begin
            win_q.push_back(cur_win());
            fd_q.push_back(oFrameDone);
            if (win_q.size() == 1) first_emit_pix = int'(p);
        end
        if (oFrameDone && !oDataValid) fd_stray++;
        if (oSofErr) sof_err_cnt++;
    endtask

    task automatic clear_mon();
        win_q.delete();
        fd_q.delete();
        sof_err_cnt    = 0;
        fd_stray       = 0;
        first_emit_pix = -1;
    endtask

    task automatic send_frame(input int base, input logic sof);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                drive(1'b0, 1'b1, sof && r == 0 && c == 0, 8'(base + 10 * r + c));
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 8'h55);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        checks++; if (cur_win() !== 72'h0) begin errors++; $display("FAIL reset_win: got %h want 0", cur_win()); end
        checks++; if (oDataValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", oDataValid); end
        checks++; if (oFrameDone !== 1'b0) begin errors++; $display("FAIL reset_fdone: got %b want 0", oFrameDone); end
        checks++; if (oSofErr !== 1'b0) begin errors++; $display("FAIL reset_soferr: got %b want 0", oSofErr); end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_frame();
        clear_mon();
        send_frame(0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        checks++; if (win_q.size() != 6) begin errors++; $display("FAIL frame_count: got %0d want 6", win_q.size()); end
        checks++; if (win_q.size() < 1 || win_q[0] !== 72'h00_01_02_0A_0B_0C_14_15_16) begin
            errors++; $display("FAIL frame_first_win: got %h want 0001020a0b0c141516", (win_q.size() > 0) ? win_q[0] : 72'hx);
        end
        checks++; if (first_emit_pix != 22) begin errors++; $display("FAIL frame_latency: first window after pixel %0d want 22", first_emit_pix); end
        for (int k = 0; k < 6 && k < win_q.size(); k++) begin
            checks++; if (win_q[k] !== win_at(0, 1 + k / 3, 1 + k % 3)) begin
                errors++; $display("FAIL frame_win%0d: got %h want %h", k, win_q[k], win_at(0, 1 + k / 3, 1 + k % 3));
            end
            checks++; if (fd_q[k] !== (k == 5)) begin errors++; $display("FAIL frame_fdone%0d: got %b want %b", k, fd_q[k], k == 5); end
        end
        checks++; if (sof_err_cnt != 0 || fd_stray != 0) begin
            errors++; $display("FAIL frame_pulses: soferr=%0d stray_fdone=%0d want 0/0", sof_err_cnt, fd_stray);
        end
    endtask

    task automatic test_gaps();
        logic [71:0] snap;
        int          n;
        clear_mon();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive(1'b0, 1'b1, r == 0 && c == 0, 8'(10 * r + c));
                snap = cur_win();
                n = $urandom_range(0, 3);
                for (int g = 0; g < n; g++) begin
                    drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
                    checks++; if (oDataValid !== 1'b0 || cur_win() !== snap) begin
                        errors++; $display("FAIL gap_hold r%0d c%0d: valid=%b win=%h want 0 %h", r, c, oDataValid, cur_win(), snap);
                    end
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        checks++; if (win_q.size() != 6) begin errors++; $display("FAIL gap_count: got %0d want 6", win_q.size()); end
        for (int k = 0; k < 6 && k < win_q.size(); k++) begin
            checks++; if (win_q[k] !== win_at(0, 1 + k / 3, 1 + k % 3) || fd_q[k] !== (k == 5)) begin
                errors++; $display("FAIL gap_win%0d: got %h fd=%b want %h fd=%b", k, win_q[k], fd_q[k], win_at(0, 1 + k / 3, 1 + k % 3), k == 5);
            end
        end
        checks++; if (sof_err_cnt != 0 || fd_stray != 0) begin
            errors++; $display("FAIL gap_pulses: soferr=%0d stray_fdone=%0d want 0/0", sof_err_cnt, fd_stray);
        end
    endtask

    task automatic test_back_to_back();
        int nfd;
        clear_mon();
        send_frame(0, 1'b1);
        send_frame(100, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        checks++; if (win_q.size() != 12) begin errors++; $display("FAIL b2b_count: got %0d want 12", win_q.size()); end
        nfd = 0;
        for (int k = 0; k < 12 && k < win_q.size(); k++) begin
            if (fd_q[k]) nfd++;
            checks++; if (win_q[k] !== win_at((k < 6) ? 0 : 100, 1 + (k % 6) / 3, 1 + k % 3)) begin
                errors++; $display("FAIL b2b_win%0d: got %h want %h", k, win_q[k], win_at((k < 6) ? 0 : 100, 1 + (k % 6) / 3, 1 + k % 3));
            end
        end
        checks++; if (nfd != 2 || fd_stray != 0) begin errors++; $display("FAIL b2b_fdone: got %0d pulses (%0d stray) want 2", nfd, fd_stray); end
        checks++; if (sof_err_cnt != 0) begin errors++; $display("FAIL b2b_soferr: got %0d want 0", sof_err_cnt); end
    endtask

    task automatic test_sof_err();
        clear_mon();
        for (int idx = 0; idx < 2 * W + 3; idx++)
            drive(1'b0, 1'b1, idx == 0, 8'(10 * (idx / W) + idx % W));
        drive(1'b0, 1'b1, 1'b1, 8'd100);
        checks++; if (oSofErr !== 1'b1) begin errors++; $display("FAIL soferr_pulse: got %b want 1", oSofErr); end
        for (int idx = 1; idx < W * H; idx++) begin
            drive(1'b0, 1'b1, 1'b0, 8'(100 + 10 * (idx / W) + idx % W));
            if (idx == 1) begin
                checks++; if (oSofErr !== 1'b0) begin errors++; $display("FAIL soferr_one_cycle: got %b want 0", oSofErr); end
            end
            if (idx == 2 * W + 1) begin
                checks++; if (win_q.size() != 1) begin errors++; $display("FAIL soferr_quiet: got %0d windows want 1", win_q.size()); end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        checks++; if (win_q.size() != 7) begin errors++; $display("FAIL soferr_count: got %0d want 7", win_q.size()); end
        checks++; if (win_q.size() < 2 || win_q[0] !== win_at(0, 1, 1) || win_q[1][71:48] !== 24'h64_65_66) begin
            errors++; $display("FAIL soferr_resync: got %h / %h want %h / 646566...", (win_q.size() > 0) ? win_q[0] : 72'hx,
                               (win_q.size() > 1) ? win_q[1] : 72'hx, win_at(0, 1, 1));
        end
        for (int k = 1; k < 7 && k < win_q.size(); k++) begin
            checks++; if (win_q[k] !== win_at(100, 1 + (k - 1) / 3, 1 + (k - 1) % 3)) begin
                errors++; $display("FAIL soferr_win%0d: got %h want %h", k, win_q[k], win_at(100, 1 + (k - 1) / 3, 1 + (k - 1) % 3));
            end
        end
        checks++; if (sof_err_cnt != 1) begin errors++; $display("FAIL soferr_total: got %0d want 1", sof_err_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        for (int idx = 0; idx < 2 * W + 3; idx++)
            drive(1'b0, 1'b1, idx == 0, 8'(10 * (idx / W) + idx % W));
        checks++; if (win_q.size() != 1 || oDataValid !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: got %0d windows valid=%b want 1/1", win_q.size(), oDataValid);
        end
        drive(1'b1, 1'b1, 1'b1, 8'h77);
        checks++; if (cur_win() !== 72'h0 || oDataValid !== 1'b0 || oFrameDone !== 1'b0 || oSofErr !== 1'b0) begin
            errors++; $display("FAIL rstmid_clear: got win=%h v=%b fd=%b se=%b want all 0", cur_win(), oDataValid, oFrameDone, oSofErr);
        end
        clear_mon();
        send_frame(0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        checks++; if (win_q.size() != 6 || first_emit_pix != 22) begin
            errors++; $display("FAIL rstmid_count: got %0d windows first after %0d want 6 after 22", win_q.size(), first_emit_pix);
        end
        for (int k = 0; k < 6 && k < win_q.size(); k++) begin
            checks++; if (win_q[k] !== win_at(0, 1 + k / 3, 1 + k % 3) || fd_q[k] !== (k == 5)) begin
                errors++; $display("FAIL rstmid_win%0d: got %h fd=%b want %h fd=%b", k, win_q[k], fd_q[k], win_at(0, 1 + k / 3, 1 + k % 3), k == 5);
            end
        end
    endtask

    initial begin
        iRst = 1'b1; iDataValid = 1'b0; iSof = 1'b0; iv8Pixel = 8'h00;
        clear_mon();
        test_reset();
        test_frame();
        test_gaps();
        test_back_to_back();
        test_sof_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
